// File: rtl/psx_host_poller.sv
// PSX bus master: polls a controller with 0x01,0x42,0x00..., sizes the packet
// from the ID byte and forwards every received byte to a write port.
module psx_host_poller #(
  parameter int HALF_PERIOD = 96,
  parameter int SEL_SETUP   = 960,
  parameter int ACK_TIMEOUT = 4800,
  parameter int BYTE_GAP    = 96,
  parameter int MAX_BYTES   = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       PSX_SEL,
  output logic       PSX_CLK,
  output logic       PSX_CMD,
  input  logic       PSX_DAT,
  input  logic       PSX_ACK,
  output logic [4:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_en,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state    | meaning
  // IDLE     | bus released, waiting for start
  // SETUP    | SEL low, waiting before the first clock fall
  // BIT_LO   | CLK low, CMD bit driven
  // BIT_HI   | CLK high, DAT bit captured on entry
  // ACK_WAIT | waiting for ACK pulse (low then high) from the pad
  // GAP      | inter-byte pause
  // FINISH   | release SEL, pulse done
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] BIT_LO   = 3'd2;
  localparam logic [2:0] BIT_HI   = 3'd3;
  localparam logic [2:0] ACK_WAIT = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;
  localparam logic [2:0] FINISH   = 3'd6;

  localparam int CNT_A   = (HALF_PERIOD > BYTE_GAP) ? HALF_PERIOD : BYTE_GAP;
  localparam int CNT_B   = (SEL_SETUP > ACK_TIMEOUT) ? SEL_SETUP : ACK_TIMEOUT;
  localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [5:0] MAX_LEN = 6'(MAX_BYTES);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [4:0]    byte_idx;
  logic [5:0]    length;
  logic [7:0]    rx_shift;
  logic          ack_seen;
  logic          dat_s1, dat_s2, ack_s1, ack_s2;

  logic [5:0] len_raw, len_calc, eff_len;
  logic       last_byte;

  function automatic logic tx_bit(input logic [4:0] idx, input logic [2:0] b);
    logic [7:0] tx;
    tx = 8'h00;
    if (idx == 5'd0)      tx = 8'h01;
    else if (idx == 5'd1) tx = 8'h42;
    return tx[b];
  endfunction

  // ID byte low nibble gives half-word count; zero means unknown, use the cap
  always_comb begin
    len_raw  = 6'd3 + {1'b0, rx_shift[3:0], 1'b0};
    len_calc = len_raw;
    if (rx_shift[3:0] == 4'd0 || len_raw > MAX_LEN) len_calc = MAX_LEN;
    eff_len   = (byte_idx == 5'd1) ? len_calc : length;
    last_byte = ({1'b0, byte_idx} == eff_len - 6'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      dat_s1 <= PSX_DAT;
      dat_s2 <= dat_s1;
      ack_s1 <= PSX_ACK;
      ack_s2 <= ack_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      length     <= MAX_LEN;
      rx_shift   <= '0;
      ack_seen   <= 1'b0;
      PSX_SEL    <= 1'b1;
      PSX_CLK    <= 1'b1;
      PSX_CMD    <= 1'b1;
      write_addr <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          // a start coinciding with the completion pulse is dropped
          if (start && !done && !error) begin
            PSX_SEL  <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            bit_idx  <= '0;
            length   <= MAX_LEN;
            cnt      <= CW'(SEL_SETUP - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            PSX_CLK <= 1'b0;
            PSX_CMD <= tx_bit(byte_idx, 3'd0);
            cnt     <= CW'(HALF_PERIOD - 1);
            state   <= BIT_LO;
          end else cnt <= cnt - 1'b1;
        end
        BIT_LO: begin
          if (cnt == '0) begin
            PSX_CLK  <= 1'b1;
            rx_shift <= {dat_s2, rx_shift[7:1]};
            cnt      <= CW'(HALF_PERIOD - 1);
            state    <= BIT_HI;
          end else cnt <= cnt - 1'b1;
        end
        BIT_HI: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 3'd1;
            PSX_CLK <= 1'b0;
            PSX_CMD <= tx_bit(byte_idx, bit_idx + 3'd1);
            cnt     <= CW'(HALF_PERIOD - 1);
            state   <= BIT_LO;
          end else begin
            write_en   <= 1'b1;
            write_addr <= byte_idx;
            write_data <= rx_shift;
            PSX_CMD    <= 1'b1;
            bit_idx    <= '0;
            if (byte_idx == 5'd1) length <= len_calc;
            if (byte_idx == 5'd2 && rx_shift != 8'h5A) begin
              PSX_SEL <= 1'b1;
              PSX_CLK <= 1'b1;
              error   <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else if (last_byte) begin
              state <= FINISH;
            end else begin
              ack_seen <= 1'b0;
              cnt      <= CW'(ACK_TIMEOUT - 1);
              state    <= ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (!ack_seen) begin
            if (!ack_s2) ack_seen <= 1'b1;
            else if (cnt == '0) begin
              PSX_SEL <= 1'b1;
              PSX_CLK <= 1'b1;
              PSX_CMD <= 1'b1;
              error   <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else cnt <= cnt - 1'b1;
          end else if (ack_s2) begin
            cnt   <= CW'(BYTE_GAP - 1);
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            byte_idx <= byte_idx + 5'd1;
            PSX_CLK  <= 1'b0;
            PSX_CMD  <= tx_bit(byte_idx + 5'd1, 3'd0);
            cnt      <= CW'(HALF_PERIOD - 1);
            state    <= BIT_LO;
          end else cnt <= cnt - 1'b1;
        end
        FINISH: begin
          PSX_SEL <= 1'b1;
          PSX_CLK <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psx_host_poller.sv
// Bench for psx_host_poller: behavioural pad model plus directed/randomized polls.
module tb_psx_host_poller;
  localparam int HP     = 6;
  localparam int SETUP  = 30;
  localparam int ACK_TO = 100;
  localparam int GAPC   = 6;
  localparam int MAXB   = 21;
  localparam int LIMIT  = 20000;

  logic clk = 1'b0;
  logic reset, start;
  logic PSX_SEL, PSX_CLK, PSX_CMD;
  logic PSX_DAT = 1'b1;
  logic PSX_ACK = 1'b1;
  logic [4:0] write_addr;
  logic [7:0] write_data;
  logic write_en, busy, done, error;

  always #5 clk = ~clk;

  psx_host_poller #(.HALF_PERIOD(HP), .SEL_SETUP(SETUP), .ACK_TIMEOUT(ACK_TO),
                    .BYTE_GAP(GAPC), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .PSX_SEL(PSX_SEL), .PSX_CLK(PSX_CLK), .PSX_CMD(PSX_CMD),
    .PSX_DAT(PSX_DAT), .PSX_ACK(PSX_ACK),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .busy(busy), .done(done), .error(error));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pad configuration, written only by the stimulus process
  logic [7:0] reply [32];
  int reply_len = 0;
  int ack_limit = 32;

  // monitor/pad state, written only by the monitor process
  int cyc = 0;
  int pad_byte = 0, pad_bit = 0;
  int ack_delay = 0, ack_hold = 0, acks_issued = 0;
  int t_sel = 0, t_fall = 0, t_rise = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0, sel_falls = 0;
  logic prev_clk = 1'b1, prev_sel = 1'b1, first_fall = 1'b1;
  logic [7:0] cmd_rise, cmd_fall;
  logic [7:0] cmd_q [$];
  logic [7:0] cmdf_q [$];
  logic [12:0] wq [$];
  int we_cyc [$];
  int setup_q [$];
  int low_q [$];
  int high_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      wq.push_back({write_addr, write_data});
      we_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (done === 1'b1 && error === 1'b1) both_cnt++;
    if (PSX_SEL !== 1'b0) begin
      pad_byte = 0; pad_bit = 0; PSX_DAT = 1'b1; PSX_ACK = 1'b1;
      ack_delay = 0; ack_hold = 0; first_fall = 1'b1;
    end else begin
      if (prev_sel !== 1'b0) begin t_sel = cyc; sel_falls++; end
      if (prev_clk === 1'b1 && PSX_CLK === 1'b0) begin
        if (first_fall) setup_q.push_back(cyc - t_sel);
        else if (pad_bit != 0) high_q.push_back(cyc - t_rise);
        first_fall = 1'b0;
        t_fall = cyc;
        cmd_fall[pad_bit] = PSX_CMD;
        PSX_DAT = (pad_byte < reply_len) ? reply[pad_byte][pad_bit] : 1'b1;
      end
      if (prev_clk === 1'b0 && PSX_CLK === 1'b1) begin
        low_q.push_back(cyc - t_fall);
        t_rise = cyc;
        cmd_rise[pad_bit] = PSX_CMD;
        pad_bit++;
        if (pad_bit == 8) begin
          cmd_q.push_back(cmd_rise);
          cmdf_q.push_back(cmd_fall);
          pad_bit = 0;
          if (pad_byte < ack_limit && pad_byte < reply_len - 1)
            ack_delay = HP + int'($urandom_range(0, 8));
          pad_byte++;
        end
      end
      if (ack_delay > 0) begin
        ack_delay--;
        if (ack_delay == 0) begin PSX_ACK = 1'b0; ack_hold = 4; acks_issued++; end
      end else if (ack_hold > 0) begin
        ack_hold--;
        if (ack_hold == 0) PSX_ACK = 1'b1;
      end
    end
    prev_clk = PSX_CLK;
    prev_sel = PSX_SEL;
  end

  function automatic int ref_len(input logic [7:0] id);
    int n, l;
    n = int'(id[3:0]);
    l = (n == 0) ? MAXB : 3 + 2 * n;
    if (l > MAXB) l = MAXB;
    return l;
  endfunction

  function automatic logic [7:0] exp_cmd(input int i);
    return (i == 0) ? 8'h01 : (i == 1) ? 8'h42 : 8'h00;
  endfunction

  task automatic fill_reply(input logic [7:0] id, input int len);
    reply[0] = 8'hFF; reply[1] = id; reply[2] = 8'h5A;
    for (int i = 3; i < 32; i++) reply[i] = 8'($urandom);
    reply_len = len;
  endtask

  task automatic run_txn(input string name, input int exp_len, input bit exp_err,
                         input bit timeout_case, input bit extra_starts);
    int guard, b_w, b_c, b_s, b_l, b_h, d0, e0, a0, s0, bo0;
    logic [12:0] e;
    b_w = wq.size(); b_c = cmd_q.size(); b_s = setup_q.size();
    b_l = low_q.size(); b_h = high_q.size();
    d0 = done_cnt; e0 = err_cnt; a0 = acks_issued; s0 = sel_falls; bo0 = both_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, " busy_on"}, busy, 1);
    check({name, " sel_low"}, PSX_SEL, 0);
    guard = 0;
    while (!(done === 1'b1 || error === 1'b1) && guard < LIMIT) begin
      @(negedge clk); guard++;
      start = extra_starts && (guard % 150 == 100);
    end
    start = extra_starts;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    check({name, " finished"}, guard < LIMIT, 1);
    check({name, " done_cnt"}, done_cnt - d0, exp_err ? 0 : 1);
    check({name, " err_cnt"}, err_cnt - e0, exp_err ? 1 : 0);
    check({name, " done_with_err"}, both_cnt - bo0, 0);
    check({name, " sel_falls"}, sel_falls - s0, 1);
    check({name, " n_writes"}, wq.size() - b_w, exp_len);
    for (int i = 0; i < exp_len && b_w + i < wq.size(); i++) begin
      e = wq[b_w + i];
      check($sformatf("%s addr%0d", name, i), e[12:8], i);
      check($sformatf("%s data%0d", name, i), e[7:0], reply[i]);
    end
    check({name, " bytes_clocked"}, cmd_q.size() - b_c, exp_len);
    for (int i = 0; b_c + i < cmd_q.size(); i++) begin
      check($sformatf("%s cmd_rise%0d", name, i), cmd_q[b_c + i], exp_cmd(i));
      check($sformatf("%s cmd_fall%0d", name, i), cmdf_q[b_c + i], exp_cmd(i));
    end
    check({name, " setup_seen"}, setup_q.size() - b_s, 1);
    for (int i = b_s; i < setup_q.size(); i++) check({name, " sel_to_clk"}, setup_q[i], SETUP);
    for (int i = b_l; i < low_q.size(); i++) check({name, " clk_low"}, low_q[i], HP);
    for (int i = b_h; i < high_q.size(); i++) check({name, " clk_high"}, high_q[i], HP);
    check({name, " sel_idle"}, PSX_SEL, 1);
    check({name, " clk_idle"}, PSX_CLK, 1);
    check({name, " cmd_idle"}, PSX_CMD, 1);
    check({name, " busy_off"}, busy, 0);
    if (!exp_err) check({name, " acks"}, acks_issued - a0, exp_len - 1);
    if (timeout_case && we_cyc.size() > b_w)
      check({name, " timeout_cycles"}, err_cyc - we_cyc[b_w], ACK_TO);
  endtask

  initial begin
    logic [7:0] id;
    int guard, d0, e0, w0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst sel", PSX_SEL, 1);
    check("rst clk", PSX_CLK, 1);
    check("rst cmd", PSX_CMD, 1);
    check("rst write_en", write_en, 0);
    check("rst write_addr", write_addr, 0);
    check("rst write_data", write_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    fill_reply(8'h41, 5); reply[3] = 8'hFF; reply[4] = 8'hFE;
    run_txn("digital", 5, 0, 0, 0);

    fill_reply(8'h73, ref_len(8'h73));
    run_txn("analog", 9, 0, 0, 0);

    fill_reply(8'h70, MAXB);
    run_txn("id70", MAXB, 0, 0, 0);

    for (int k = 0; k < 3; k++) begin
      id = {4'($urandom), 4'($urandom_range(1, 15))};
      fill_reply(id, ref_len(id));
      run_txn($sformatf("rand_id_%02h", id), ref_len(id), 0, 0, 0);
    end

    fill_reply(8'h41, 5); ack_limit = 0;
    run_txn("no_ack", 1, 1, 1, 0);
    ack_limit = 32;

    fill_reply(8'h41, 5); reply[2] = 8'h00;
    run_txn("bad_marker", 3, 1, 0, 0);

    fill_reply(8'h41, 5);
    run_txn("start_busy", 5, 0, 0, 1);

    fill_reply(8'h73, 9);
    d0 = done_cnt; e0 = err_cnt; w0 = wq.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(pad_byte == 1 && pad_bit == 4 && PSX_CLK === 1'b0) && guard < LIMIT) begin
      @(negedge clk); guard++;
    end
    check("midrst reached_bit4", guard < LIMIT, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst sel", PSX_SEL, 1);
    check("midrst clk", PSX_CLK, 1);
    check("midrst busy", busy, 0);
    check("midrst write_en", write_en, 0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst done_cnt", done_cnt - d0, 0);
    check("midrst err_cnt", err_cnt - e0, 0);
    check("midrst n_writes", wq.size() - w0, 1);
    check("midrst sel_idle", PSX_SEL, 1);

    fill_reply(8'h41, 5);
    run_txn("after_reset", 5, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
